// File: rtl/riscv_logic_pipe.sv
// riscv_logic_pipe: pipelined XOR/OR/AND/XORI/ORI/ANDI execute slice with a
// private register file, a RAW scoreboard and a valid/ready issue port.
// Optional feature macro: LOGIC_TRAP_EN adds the `illegal` pulse output.
module riscv_logic_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [31:0]      retired,
`ifdef LOGIC_TRAP_EN
  output logic             illegal,
`endif
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int unsigned IDXW = $clog2(NREGS);

  typedef enum logic [6:0] {
    OPC_R = 7'b0110011,
    OPC_I = 7'b0010011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_XOR = 3'b100,
    F3_OR  = 3'b110,
    F3_AND = 3'b111
  } funct3_e;

  // Architectural and pipeline state
  logic [XLEN-1:0] rf_q        [NREGS];
  logic [XLEN-1:0] rf_d        [NREGS];
  logic            pipe_v_q    [STAGES];
  logic            pipe_v_d    [STAGES];
  logic [4:0]      pipe_rd_q   [STAGES];
  logic [4:0]      pipe_rd_d   [STAGES];
  logic [XLEN-1:0] pipe_data_q [STAGES];
  logic [XLEN-1:0] pipe_data_d [STAGES];
  logic [31:0]     retired_q;
  logic [31:0]     retired_d;
`ifdef LOGIC_TRAP_EN
  logic            illegal_q;
  logic            illegal_d;
`endif

  // Decode fields and intermediate values
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic            is_r;
  logic            is_i;
  logic            op_ok;
  logic            regs_ok;
  logic            legal;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;

  // Decode the candidate instruction and read its operands
  always_comb begin
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    funct7  = instr[31:25];
    is_r    = (opcode == OPC_R) && (funct7 == 7'b0000000);
    is_i    = (opcode == OPC_I);
    op_ok   = (funct3 == F3_XOR) || (funct3 == F3_OR) || (funct3 == F3_AND);
    // Register fields beyond the file (RV32E) are only checked where they name a register
    regs_ok = (NREGS > 16) || !(rd[4] || rs1[4] || (is_r && rs2[4]));
    legal   = (is_r || is_i) && op_ok && regs_ok;
    rs1_val = ({27'b0, rs1} < NREGS) ? rf_q[rs1[IDXW-1:0]] : '0;
    rs2_val = ({27'b0, rs2} < NREGS) ? rf_q[rs2[IDXW-1:0]] : '0;
    imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
    op_b    = is_r ? rs2_val : imm_ext;
    case (funct3)
      F3_XOR:  result = rs1_val ^ op_b;
      F3_OR:   result = rs1_val | op_b;
      F3_AND:  result = rs1_val & op_b;
      default: result = '0;
    endcase
  end

  // Scoreboard: stall a legal candidate whose sources are still in flight
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (pipe_v_q[i] && (pipe_rd_q[i] != 5'd0) &&
          ((pipe_rd_q[i] == rs1) || (is_r && (pipe_rd_q[i] == rs2)))) begin
        hazard = 1'b1;
      end
    end
    instr_ready = !legal || !hazard;
    accept      = instr_valid && instr_ready;
  end

  // Next-state: pipe shift, writeback from the last stage, retire count
  always_comb begin
    pipe_v_d[0]    = accept && legal;
    pipe_rd_d[0]   = rd;
    pipe_data_d[0] = result;
    for (int unsigned i = 1; i < STAGES; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_rd_d[i]   = pipe_rd_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
    rf_d      = rf_q;
    retired_d = retired_q;
    if (pipe_v_q[STAGES-1]) begin
      retired_d = retired_q + 32'd1;
      if (pipe_rd_q[STAGES-1] != 5'd0) begin
        rf_d[pipe_rd_q[STAGES-1][IDXW-1:0]] = pipe_data_q[STAGES-1];
      end
    end
`ifdef LOGIC_TRAP_EN
    illegal_d = accept && !legal;
`endif
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
        pipe_v_q[i]    <= 1'b0;
        pipe_rd_q[i]   <= '0;
        pipe_data_q[i] <= '0;
      end
      retired_q <= '0;
`ifdef LOGIC_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      rf_q        <= rf_d;
      pipe_v_q    <= pipe_v_d;
      pipe_rd_q   <= pipe_rd_d;
      pipe_data_q <= pipe_data_d;
      retired_q   <= retired_d;
`ifdef LOGIC_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  // The last pipe stage doubles as the registered writeback port
  assign wb_valid = pipe_v_q[STAGES-1];
  assign wb_rd    = pipe_rd_q[STAGES-1];
  assign wb_data  = pipe_data_q[STAGES-1];
  assign retired  = retired_q;
`ifdef LOGIC_TRAP_EN
  assign illegal  = illegal_q;
`endif
  assign dbg_data = ({27'b0, dbg_addr} < NREGS) ? rf_q[dbg_addr[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_riscv_logic_pipe.sv
// Self-checking bench for riscv_logic_pipe (XLEN=64, STAGES=3).
module tb_riscv_logic_pipe;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned STAGES = 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     retired;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
`ifdef LOGIC_TRAP_EN
  logic            illegal;
`endif

  always #5 clock = ~clock;

  riscv_logic_pipe #(.XLEN(XLEN), .NREGS(NREGS), .STAGES(STAGES)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .retired     (retired),
`ifdef LOGIC_TRAP_EN
    .illegal     (illegal),
`endif
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Reference model: architectural registers plus a queue of scheduled writes
  typedef struct {
    int unsigned     due;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } wr_t;

  wr_t             pend[$];
  logic [XLEN-1:0] mrf [32];
  logic [31:0]     m_retired;
  logic            m_ill;
  int unsigned     edge_n;

  int n_cmp = 0;
  int n_bad = 0;
  logic last_ready, last_wbv, last_acc, last_ill;
  logic [4:0] last_wbrd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic m_isr(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h00);
  endfunction

  function automatic logic m_legal(input logic [31:0] w);
    logic kind_ok, f_ok;
    kind_ok = m_isr(w) || (w[6:0] == 7'h13);
    f_ok    = (w[14:12] == 3'd4) || (w[14:12] == 3'd6) || (w[14:12] == 3'd7);
    return kind_ok && f_ok;
  endfunction

  function automatic logic m_ready(input logic [31:0] w);
    if (!m_legal(w)) return 1'b1;
    foreach (pend[i]) begin
      if (pend[i].rd != 0 && (pend[i].rd == w[19:15] || (m_isr(w) && pend[i].rd == w[24:20])))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] m_exec(input logic [31:0] w);
    logic [XLEN-1:0] a, b;
    a = mrf[w[19:15]];
    b = m_isr(w) ? mrf[w[24:20]] : {{(XLEN-12){w[31]}}, w[31:20]};
    case (w[14:12])
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // One clock: drive, check at negedge against the model, advance model at posedge
  task automatic cycle(input logic v, input logic [31:0] w, input logic [4:0] da);
    logic exp_rdy, acc;
    logic [XLEN-1:0] res;
    instr_valid = v;
    instr       = w;
    dbg_addr    = da;
    @(negedge clock);
    exp_rdy = m_ready(w);
    chk("instr_ready", instr_ready, exp_rdy);
    last_ready = instr_ready;
    if (pend.size() > 0 && pend[0].due == edge_n + 1) begin
      chk("wb_valid", wb_valid, 1'b1);
      chk("wb_rd", wb_rd, pend[0].rd);
      chk("wb_data", wb_data, pend[0].val);
    end else begin
      chk("wb_valid_idle", wb_valid, 1'b0);
    end
    last_wbv  = wb_valid;
    last_wbrd = wb_rd;
    chk("retired", retired, m_retired);
    chk("dbg_data", dbg_data, mrf[da]);
`ifdef LOGIC_TRAP_EN
    chk("illegal", illegal, m_ill);
    last_ill = illegal;
`endif
    acc      = v && exp_rdy;
    last_acc = acc;
    res      = m_exec(w);
    @(posedge clock);
    edge_n++;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      if (pend[0].rd != 0) mrf[pend[0].rd] = pend[0].val;
      m_retired++;
      void'(pend.pop_front());
    end
    m_ill = acc && !m_legal(w);
    if (acc && m_legal(w)) pend.push_back('{due: edge_n + STAGES, rd: w[11:7], val: res});
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, w, 5'($urandom_range(0, 31)));
      if (last_acc) break;
    end
    chk("issue_accepted", last_acc, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pend.size() > 0; i++) cycle(1'b0, 32'h0, 5'($urandom_range(0, 31)));
    cycle(1'b0, 32'h0, 5'd0);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    pend.delete();
    foreach (mrf[i]) mrf[i] = '0;
    m_retired = '0;
    m_ill     = 1'b0;
    #2;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_retired", retired, 32'd0);
`ifdef LOGIC_TRAP_EN
    chk("rst_illegal", illegal, 1'b0);
`endif
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #0.1;
      chk($sformatf("rst_rf_x%0d", a), dbg_data, 64'h0);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    edge_n++;
    #1;
  endtask

  typedef struct {
    logic [31:0] w;
    logic [4:0]  chk_reg;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] w, r0;
    logic        v;
    int          stalls, cnt, first, lastidx;
    logic        saw;
    logic [4:0]  saw_rd;

    tbl[0]  = '{i_op(3'd4, 5'd6,  5'd0,  12'h555), 5'd6,  64'h0000000000000555};
    tbl[1]  = '{i_op(3'd4, 5'd7,  5'd0,  12'hAAA), 5'd7,  64'hFFFFFFFFFFFFFAAA};
    tbl[2]  = '{r_op(3'd4, 5'd5,  5'd6,  5'd7),    5'd5,  64'hFFFFFFFFFFFFFFFF};
    tbl[3]  = '{i_op(3'd4, 5'd6,  5'd0,  12'h000), 5'd6,  64'h0000000000000000};
    tbl[4]  = '{i_op(3'd4, 5'd5,  5'd6,  12'hFFF), 5'd5,  64'hFFFFFFFFFFFFFFFF};
    tbl[5]  = '{i_op(3'd7, 5'd5,  5'd5,  12'h0F0), 5'd5,  64'h00000000000000F0};
    tbl[6]  = '{i_op(3'd6, 5'd28, 5'd0,  12'h7F0), 5'd28, 64'h00000000000007F0};
    tbl[7]  = '{r_op(3'd6, 5'd10, 5'd5,  5'd28),   5'd10, 64'h00000000000007F0};
    tbl[8]  = '{r_op(3'd7, 5'd11, 5'd10, 5'd7),    5'd11, 64'h00000000000002A0};
    tbl[9]  = '{r_op(3'd4, 5'd0,  5'd6,  5'd7),    5'd0,  64'h0000000000000000};
    tbl[10] = '{i_op(3'd7, 5'd12, 5'd7,  12'h800), 5'd12, 64'hFFFFFFFFFFFFF800};
    tbl[11] = '{r_op(3'd4, 5'd13, 5'd7,  5'd7),    5'd13, 64'h0000000000000000};

    instr = '0;
    dbg_addr = '0;
    edge_n = 0;
    do_reset();

    // Directed table, each record run to completion
    foreach (tbl[i]) begin
      issue(tbl[i].w);
      drain();
      dbg_addr = tbl[i].chk_reg;
      #1;
      chk($sformatf("tbl_%0d", i), dbg_data, tbl[i].exp);
    end
    chk("tbl_retired", retired, 32'd12);

    // RAW stall: or a0,t1,t2 then and a1,a0,t3
    issue(r_op(3'd6, 5'd10, 5'd6, 5'd7));
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, r_op(3'd7, 5'd11, 5'd10, 5'd28), 5'd0);
      if (!last_ready) stalls++;
      if (last_acc) break;
    end
    chk("raw_stall_cycles", 64'(stalls), 64'(STAGES));
    drain();
    dbg_addr = 5'd11;
    #1;
    chk("raw_result", dbg_data, 64'h00000000000002A0);

    // Independent stream of four
    r0 = retired;
    cnt = 0; first = -1; lastidx = -1;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: w = i_op(3'd4, 5'd14, 5'd0, 12'h001);
        1: w = i_op(3'd4, 5'd15, 5'd0, 12'h002);
        2: w = i_op(3'd6, 5'd16, 5'd0, 12'h003);
        3: w = i_op(3'd7, 5'd17, 5'd0, 12'h004);
        default: w = 32'h0;
      endcase
      cycle(i < 4, w, 5'd14);
      if (i < 4) chk($sformatf("stream_ready_%0d", i), last_ready, 1'b1);
      if (last_wbv) begin
        cnt++;
        if (first < 0) first = i;
        lastidx = i;
      end
    end
    chk("stream_wb_pulses", 64'(cnt), 64'd4);
    chk("stream_wb_span", 64'(lastidx - first), 64'd3);
    chk("stream_retired", retired - r0, 32'd4);

    // Write to x0 with t1=1
    issue(i_op(3'd4, 5'd6, 5'd0, 12'h001));
    drain();
    r0 = retired;
    issue(r_op(3'd4, 5'd0, 5'd6, 5'd7));
    saw = 1'b0; saw_rd = 5'h1F;
    for (int i = 0; i < 10 && !saw; i++) begin
      cycle(1'b0, 32'h0, 5'd0);
      if (last_wbv) begin saw = 1'b1; saw_rd = last_wbrd; end
    end
    chk("x0_wb_valid", saw, 1'b1);
    chk("x0_wb_rd", saw_rd, 5'd0);
    drain();
    dbg_addr = 5'd0;
    #1;
    chk("x0_dbg", dbg_data, 64'h0);
    chk("x0_retired", retired - r0, 32'd1);

    // Illegal encodings: ADD, XOR with funct7=0100000, LUI
    r0 = retired;
    issue(r_op(3'd0, 5'd5, 5'd6, 5'd7));
    cycle(1'b0, 32'h0, 5'd5);
`ifdef LOGIC_TRAP_EN
    chk("illegal_pulse", last_ill, 1'b1);
    cycle(1'b0, 32'h0, 5'd5);
    chk("illegal_once", last_ill, 1'b0);
`endif
    issue(r_op(3'd4, 5'd5, 5'd6, 5'd7) | 32'h4000_0000);
    issue({20'h12345, 5'd5, 7'b0110111});
    drain();
    chk("illegal_retired", retired - r0, 32'd0);
    dbg_addr = 5'd5;
    #1;
    chk("illegal_rd_kept", dbg_data, 64'h00000000000000F0);

    // Reset with two instructions in flight
    issue(i_op(3'd4, 5'd20, 5'd0, 12'h123));
    issue(i_op(3'd4, 5'd21, 5'd0, 12'h456));
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 5'd20);
    dbg_addr = 5'd21;
    #1;
    chk("post_rst_x21", dbg_data, 64'h0);

    // Randomized stream against the model
    v = 1'b0; w = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !last_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) < 8) begin
          logic [2:0] f3;
          case ($urandom_range(0, 2))
            0:       f3 = 3'd4;
            1:       f3 = 3'd6;
            default: f3 = 3'd7;
          endcase
          if ($urandom_range(0, 1) == 1)
            w = r_op(f3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          else
            w = i_op(f3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
        end else begin
          w = $urandom;
        end
      end
      cycle(v, w, 5'($urandom_range(0, 31)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
